// File: rtl/config_pkg.sv
// Shared types for the channel job-status tracker: the per-channel state encoding
// that software reads back and the command code values.
package config_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_DONE  = 2'd2,
    ST_ERROR = 2'd3
  } state_e;

  // Decoded command class; any code outside the three named values is BAD.
  typedef enum logic [1:0] {
    C_IDLE  = 2'd0,
    C_START = 2'd1,
    C_DONE  = 2'd2,
    C_BAD   = 2'd3
  } cmd_e;

  localparam int unsigned CMD_IDLE  = 0;
  localparam int unsigned CMD_START = 1;
  localparam int unsigned CMD_DONE  = 2;

endpackage

// File: rtl/chan_fsm.sv
// One channel of the tracker: job-status FSM with a BUSY watchdog timer and a
// saturating completed-job counter.
module chan_fsm
  import config_pkg::*;
#(
  parameter int unsigned CODE_W  = 4,
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned DCNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              code_valid_i,
  input  logic [CODE_W-1:0] code_i,
  input  logic              ack_i,
  input  logic              clear_i,
  output state_e            state_o,
  output logic [DCNT_W-1:0] done_cnt_o
);

  localparam int unsigned TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [DCNT_W-1:0] cnt_q, cnt_d;
  logic              cnt_inc;
  cmd_e              cmd;

  always_comb begin
    cmd = C_BAD;
    if (code_i == CODE_W'(CMD_IDLE))       cmd = C_IDLE;
    else if (code_i == CODE_W'(CMD_START)) cmd = C_START;
    else if (code_i == CODE_W'(CMD_DONE))  cmd = C_DONE;
  end

  // Timer defaults to 0 so it can only be nonzero while staying in BUSY.
  always_comb begin
    state_d = state_q;
    timer_d = '0;
    cnt_inc = 1'b0;
    if (clear_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (code_valid_i) begin
            if (cmd == C_START)    state_d = ST_BUSY;
            else if (cmd == C_BAD) state_d = ST_ERROR;
          end
        end
        ST_BUSY: begin
          if (code_valid_i) begin
            case (cmd)
              C_DONE: begin
                state_d = ST_DONE;
                cnt_inc = 1'b1;
              end
              C_START: state_d = ST_BUSY;
              C_IDLE:  state_d = ST_IDLE;
              default: state_d = ST_ERROR;
            endcase
          end else if (timer_q == TMAX) begin
            state_d = ST_ERROR;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        ST_DONE: begin
          if (code_valid_i) begin
            case (cmd)
              C_START: state_d = ST_BUSY;
              C_IDLE:  state_d = ST_IDLE;
              C_DONE:  state_d = ST_DONE;
              default: state_d = ST_ERROR;
            endcase
          end else if (ack_i) begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_ERROR;
      endcase
    end
  end

  assign cnt_d = (cnt_inc && (cnt_q != '1)) ? cnt_q + 1'b1 : cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      cnt_q   <= cnt_d;
    end
  end

  assign state_o    = state_q;
  assign done_cnt_o = cnt_q;

endmodule

// File: rtl/chan_state_tracker.sv
// Multi-channel job-status tracker: replicates chan_fsm per channel and packs the
// per-channel status into flat vectors plus busy/error summaries.
module chan_state_tracker
  import config_pkg::*;
#(
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned CODE_W  = 4,
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned DCNT_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        code_valid,
  input  logic [NUM_CH*CODE_W-1:0] code,
  input  logic [NUM_CH-1:0]        ack,
  input  logic [NUM_CH-1:0]        clear,
  output logic [NUM_CH*2-1:0]      state_o,
  output logic [NUM_CH-1:0]        busy_mask,
  output logic                     err_any,
  output logic [NUM_CH*DCNT_W-1:0] done_cnt
);

  state_e            ch_state [NUM_CH];
  logic [NUM_CH-1:0] err_vec;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    chan_fsm #(
      .CODE_W (CODE_W),
      .TIMEOUT(TIMEOUT),
      .DCNT_W (DCNT_W)
    ) u_chan (
      .clk         (clk),
      .rst         (rst),
      .code_valid_i(code_valid[i]),
      .code_i      (code[i*CODE_W +: CODE_W]),
      .ack_i       (ack[i]),
      .clear_i     (clear[i]),
      .state_o     (ch_state[i]),
      .done_cnt_o  (done_cnt[i*DCNT_W +: DCNT_W])
    );

    assign state_o[2*i +: 2] = ch_state[i];
    assign busy_mask[i]      = (ch_state[i] == ST_BUSY);
    assign err_vec[i]        = (ch_state[i] == ST_ERROR);
  end

  assign err_any = |err_vec;

endmodule

// File: tb/tb_chan_state_tracker.sv
// Bench for chan_state_tracker built with a short timeout and a 2-bit done counter.
module tb_chan_state_tracker;
  import config_pkg::*;

  localparam int NUM_CH  = 4;
  localparam int CODE_W  = 4;
  localparam int TIMEOUT = 4;
  localparam int DCNT_W  = 2;

  localparam logic [1:0] I_ = 2'd0, B_ = 2'd1, D_ = 2'd2, E_ = 2'd3;
  localparam int CI = 0, CS = 1, CD = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  code_valid, ack, clear;
  logic [15:0] code;
  logic [7:0]  state_o;
  logic [3:0]  busy_mask;
  logic        err_any;
  logic [7:0]  done_cnt;

  always #5 clk = ~clk;

  chan_state_tracker #(
    .NUM_CH (NUM_CH),
    .CODE_W (CODE_W),
    .TIMEOUT(TIMEOUT),
    .DCNT_W (DCNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .code_valid(code_valid),
    .code      (code),
    .ack       (ack),
    .clear     (clear),
    .state_o   (state_o),
    .busy_mask (busy_mask),
    .err_any   (err_any),
    .done_cnt  (done_cnt)
  );

  typedef struct {
    logic [3:0]  cv;
    logic [15:0] cd;
    logic [3:0]  ak;
    logic [3:0]  cl;
    logic [7:0]  st;
    logic [7:0]  cn;
  } vec_t;

  vec_t        vecs[$];
  logic [15:0] exp_q[$];
  int          n_vec  = 0;
  int          n_miss = 0;

  function automatic logic [15:0] cd(input int ch, input int c);
    logic [15:0] r;
    logic [3:0]  cc;
    r  = '0;
    cc = c[3:0];
    r[ch*4 +: 4] = cc;
    return r;
  endfunction

  function automatic logic [7:0] st(input logic [1:0] s3, s2, s1, s0);
    return {s3, s2, s1, s0};
  endfunction

  function automatic logic [7:0] cn(input logic [1:0] c3, c2, c1, c0);
    return {c3, c2, c1, c0};
  endfunction

  task automatic add(input logic [3:0] cv, input logic [15:0] cdv, input logic [3:0] ak,
                     input logic [3:0] cl, input logic [7:0] s, input logic [7:0] c);
    vec_t v;
    v.cv = cv; v.cd = cdv; v.ak = ak; v.cl = cl; v.st = s; v.cn = c;
    vecs.push_back(v);
  endtask

  task automatic compare(input string tag);
    logic [15:0] e;
    logic [3:0]  eb;
    logic        ee;
    if (exp_q.size() == 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL %s: scoreboard empty, nothing expected", tag);
      return;
    end
    e  = exp_q.pop_front();
    eb = '0;
    ee = 1'b0;
    for (int c = 0; c < 4; c++) begin
      eb[c] = (e[8 + 2*c +: 2] == B_);
      if (e[8 + 2*c +: 2] == E_) ee = 1'b1;
    end
    n_vec++;
    if (state_o !== e[15:8]) begin
      n_miss++;
      $display("FAIL %s state_o: got %h expected %h", tag, state_o, e[15:8]);
    end
    n_vec++;
    if (busy_mask !== eb) begin
      n_miss++;
      $display("FAIL %s busy_mask: got %b expected %b", tag, busy_mask, eb);
    end
    n_vec++;
    if (err_any !== ee) begin
      n_miss++;
      $display("FAIL %s err_any: got %b expected %b", tag, err_any, ee);
    end
    n_vec++;
    if (done_cnt !== e[7:0]) begin
      n_miss++;
      $display("FAIL %s done_cnt: got %h expected %h", tag, done_cnt, e[7:0]);
    end
  endtask

  initial begin
    logic [7:0]  c1;
    logic [15:0] rnd;
    logic [15:0] cw;

    // ch0 single job, then ack in DONE
    add(4'b0001, cd(0, CS), 4'b0000, 4'b0000, st(I_, I_, I_, B_), cn(0, 0, 0, 0));
    add(4'b0000, 16'h0,     4'b0000, 4'b0000, st(I_, I_, I_, B_), cn(0, 0, 0, 0));
    add(4'b0000, 16'h0,     4'b0000, 4'b0000, st(I_, I_, I_, B_), cn(0, 0, 0, 0));
    add(4'b0001, cd(0, CD), 4'b0000, 4'b0000, st(I_, I_, I_, D_), cn(0, 0, 0, 1));
    add(4'b0000, 16'h0,     4'b0001, 4'b0000, st(I_, I_, I_, I_), cn(0, 0, 0, 1));
    c1 = cn(0, 0, 0, 1);
    // ch1 timer reload, then timeout after exactly TIMEOUT idle BUSY cycles
    add(4'b0010, cd(1, CS), 4'b0001, 4'b0000, st(I_, I_, B_, I_), c1);
    add(4'b0000, 16'h0,     4'b0000, 4'b0000, st(I_, I_, B_, I_), c1);
    add(4'b0000, 16'h0,     4'b0000, 4'b0000, st(I_, I_, B_, I_), c1);
    add(4'b0010, cd(1, CS), 4'b0000, 4'b0000, st(I_, I_, B_, I_), c1);
    add(4'b0000, 16'h0,     4'b0000, 4'b0000, st(I_, I_, B_, I_), c1);
    add(4'b0000, 16'h0,     4'b0000, 4'b0000, st(I_, I_, B_, I_), c1);
    add(4'b0000, 16'h0,     4'b0000, 4'b0000, st(I_, I_, B_, I_), c1);
    add(4'b0000, 16'h0,     4'b0000, 4'b0000, st(I_, I_, E_, I_), c1);
    add(4'b0010, cd(1, CS), 4'b0010, 4'b0000, st(I_, I_, E_, I_), c1);
    add(4'b0000, 16'h0,     4'b0000, 4'b0010, st(I_, I_, I_, I_), c1);
    // ch2 START+ack in DONE wins, timer restarts from 0
    add(4'b0100, cd(2, CS), 4'b0000, 4'b0000, st(I_, B_, I_, I_), c1);
    add(4'b0100, cd(2, CD), 4'b0000, 4'b0000, st(I_, D_, I_, I_), cn(0, 1, 0, 1));
    add(4'b0100, cd(2, CS), 4'b0100, 4'b0000, st(I_, B_, I_, I_), cn(0, 1, 0, 1));
    add(4'b0000, 16'h0,     4'b0000, 4'b0000, st(I_, B_, I_, I_), cn(0, 1, 0, 1));
    add(4'b0000, 16'h0,     4'b0000, 4'b0000, st(I_, B_, I_, I_), cn(0, 1, 0, 1));
    add(4'b0000, 16'h0,     4'b0000, 4'b0000, st(I_, B_, I_, I_), cn(0, 1, 0, 1));
    add(4'b0100, cd(2, CD), 4'b0000, 4'b0000, st(I_, D_, I_, I_), cn(0, 2, 0, 1));
    add(4'b0000, 16'h0,     4'b0100, 4'b0000, st(I_, I_, I_, I_), cn(0, 2, 0, 1));
    // ch3 bad code in IDLE and BUSY; clear beats a valid START
    add(4'b1000, cd(3, 7),  4'b0000, 4'b0000, st(E_, I_, I_, I_), cn(0, 2, 0, 1));
    add(4'b1000, cd(3, CS), 4'b0000, 4'b1000, st(I_, I_, I_, I_), cn(0, 2, 0, 1));
    add(4'b1000, cd(3, CS), 4'b0000, 4'b0000, st(B_, I_, I_, I_), cn(0, 2, 0, 1));
    add(4'b1000, cd(3, 7),  4'b0000, 4'b0000, st(E_, I_, I_, I_), cn(0, 2, 0, 1));
    add(4'b0000, 16'h0,     4'b0000, 4'b1000, st(I_, I_, I_, I_), cn(0, 2, 0, 1));
    // ch0 four more jobs: counter saturates at 3, ch1 stays at 0
    add(4'b0001, cd(0, CS), 4'b0000, 4'b0000, st(I_, I_, I_, B_), cn(0, 2, 0, 1));
    add(4'b0001, cd(0, CD), 4'b0000, 4'b0000, st(I_, I_, I_, D_), cn(0, 2, 0, 2));
    add(4'b0001, cd(0, CS), 4'b0000, 4'b0000, st(I_, I_, I_, B_), cn(0, 2, 0, 2));
    add(4'b0001, cd(0, CD), 4'b0000, 4'b0000, st(I_, I_, I_, D_), cn(0, 2, 0, 3));
    add(4'b0001, cd(0, CS), 4'b0000, 4'b0000, st(I_, I_, I_, B_), cn(0, 2, 0, 3));
    add(4'b0001, cd(0, CD), 4'b0000, 4'b0000, st(I_, I_, I_, D_), cn(0, 2, 0, 3));
    add(4'b0001, cd(0, CS), 4'b0000, 4'b0000, st(I_, I_, I_, B_), cn(0, 2, 0, 3));
    add(4'b0001, cd(0, CD), 4'b0000, 4'b0000, st(I_, I_, I_, D_), cn(0, 2, 0, 3));
    // DONE cmd in IDLE holds; IDLE cmd aborts BUSY and leaves DONE
    add(4'b0010, cd(1, CD), 4'b0000, 4'b0000, st(I_, I_, I_, D_), cn(0, 2, 0, 3));
    add(4'b1000, cd(3, CS), 4'b0000, 4'b0000, st(B_, I_, I_, D_), cn(0, 2, 0, 3));
    add(4'b1000, cd(3, CI), 4'b0000, 4'b0000, st(I_, I_, I_, D_), cn(0, 2, 0, 3));
    add(4'b0001, cd(0, CI), 4'b0000, 4'b0000, st(I_, I_, I_, I_), cn(0, 2, 0, 3));
    // mixed state ahead of the asynchronous reset
    add(4'b0111, cd(0, CS) | cd(1, 3) | cd(2, CS), 4'b0000, 4'b0000,
        st(I_, B_, E_, B_), cn(0, 2, 0, 3));
    add(4'b0100, cd(2, CD), 4'b0000, 4'b0000, st(I_, D_, E_, B_), cn(0, 3, 0, 3));

    rst = 1'b1;
    code_valid = '0; code = '0; ack = '0; clear = '0;
    repeat (2) @(negedge clk);
    exp_q.push_back(16'h0);
    compare("reset");
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rnd = 16'($urandom_range(0, 65535));
      cw  = '0;
      for (int c = 0; c < 4; c++)
        cw[c*4 +: 4] = vecs[i].cv[c] ? vecs[i].cd[c*4 +: 4] : rnd[c*4 +: 4];
      code_valid = vecs[i].cv;
      code       = cw;
      ack        = vecs[i].ak;
      clear      = vecs[i].cl;
      exp_q.push_back({vecs[i].st, vecs[i].cn});
      @(posedge clk);
      #1;
      compare($sformatf("vec%0d", i));
    end

    // Asynchronous reset mid-cycle: outputs must clear before the next edge.
    @(negedge clk);
    code_valid = '0; code = '0; ack = '0; clear = '0;
    #2;
    rst = 1'b1;
    #1;
    exp_q.push_back(16'h0);
    compare("async_rst");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    exp_q.push_back(16'h0);
    compare("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/chan_state_tracker.md
Name: chan_state_tracker

Overview:
- Multi-channel, registered successor of the single-channel combinational code-to-state decoder.
- Each channel runs a job-status FSM (IDLE/BUSY/DONE/ERROR) driven by a valid-qualified command code, with a BUSY timeout, acknowledge and sticky-error clear.
- Exports per-channel state, a busy mask, an error summary and saturating completion counters to the status/CSR layer.

Parameters:
NUM_CH, 4, number of independent channels (>=1)
CODE_W, 4, command code width per channel (>=2)
TIMEOUT, 15, max consecutive BUSY cycles without a command before ERROR (>=2)
DCNT_W, 8, width of per-channel completed-job counter

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset; asynchronous, active-high
code_valid  input  NUM_CH  per-channel command strobe
code  input  NUM_CH*CODE_W  per-channel command; channel i at [i*CODE_W +: CODE_W]
ack  input  NUM_CH  per-channel DONE acknowledge
clear  input  NUM_CH  per-channel ERROR clear / force-IDLE
state_o  output  NUM_CH*2  per-channel config_pkg::state_e; channel i at [2i +: 2]
busy_mask  output  NUM_CH  bit i = channel i in BUSY
err_any  output  1  OR of all channels in ERROR
done_cnt  output  NUM_CH*DCNT_W  per-channel saturating count of BUSY->DONE transitions

Behaviour:
- Reset: all states IDLE, timers 0, done_cnt 0, busy_mask 0, err_any 0. Reset mid-job aborts with no counter update.
- All outputs registered or decoded from registered state only: a command sampled at edge t is visible after edge t.
- Code mapping: 0 = CMD_IDLE, 1 = CMD_START, 2 = CMD_DONE, any other value = CMD_BAD.
- Priority per channel per cycle: clear > code_valid command > ack > timeout.
- clear=1: next state IDLE from any state; timer 0; done_cnt unchanged.
- IDLE:
  - START -> BUSY, timer 0
  - BAD -> ERROR
  - IDLE or DONE command -> stay IDLE
  - ack ignored
- BUSY:
  - DONE -> DONE; done_cnt+1, saturating at 2^DCNT_W-1
  - START -> stay BUSY, timer reloads to 0
  - IDLE -> IDLE (abort, no count)
  - BAD -> ERROR
  - no valid: if timer==TIMEOUT-1 -> ERROR, else timer+1. Max BUSY residency without a command is TIMEOUT cycles.
- DONE:
  - START -> BUSY, timer 0; implicit ack, START wins over a simultaneous ack
  - BAD -> ERROR
  - IDLE command -> IDLE
  - ack with no valid -> IDLE
  - otherwise hold
- ERROR: sticky; only clear or rst leaves it. code_valid and ack are ignored.
- Timer width is $clog2(TIMEOUT). It only advances in BUSY and is 0 in every other state.
- Channels are fully independent; no cross-channel arbitration.
- err_any and busy_mask are combinational decodes of the registered states, with no extra latency.

Decomposition:
- config_pkg holds state_e (2-bit, IDLE=0, BUSY=1, DONE=2, ERROR=3) plus the code localparams CMD_IDLE, CMD_START, CMD_DONE.
- Sub-module chan_fsm: one channel (FSM, timer, done counter), taking TIMEOUT, CODE_W and DCNT_W. It is instantiated NUM_CH times in a generate loop.
- Top level does only slicing, busy_mask packing and the err_any reduction.

Test Plan:
- Reset, then ch0 START @t, DONE @t+3 -> state_o[1:0] BUSY after t, DONE after t+3; done_cnt[0]=1; busy_mask[0] 1 for 3 cycles.
- TIMEOUT=4, ch1 START then no commands -> BUSY for exactly 4 cycles, then ERROR; err_any=1; later ack and START ignored; clear -> IDLE, err_any=0.
- ch2 in DONE, START and ack in the same cycle -> BUSY (not IDLE), timer 0; separately, ack alone in DONE -> IDLE next cycle.
- ch3 code=4'd7 valid in IDLE, and in another run in BUSY -> ERROR; clear together with a valid START -> IDLE (clear wins).
- DCNT_W=2, 5 START/DONE jobs on ch0 -> done_cnt[0] saturates at 3. Meanwhile ch1 stays IDLE with counter 0, confirming channel isolation.
- Assert rst asynchronously mid-BUSY with other channels in DONE/ERROR -> all outputs 0/IDLE immediately, without waiting for a clock edge.
